hilo_ctrl: RTL and testbench
============================

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 op_valid  in  1  decode stage presents a HI/LO-class instruction.
REQ-004 op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
REQ-005 rs_val  in  32  first operand / MTHI-MTLO source.
REQ-006 rt_val  in  32  second operand.
REQ-007 stall  out  1  combinational; holds decode stage.
REQ-008 rd_val  out  32  combinational MFHI/MFLO result.
REQ-009 md_start  out  1  one-cycle issue pulse to mul/div unit.
REQ-010 md_func  out  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-011 md_a, md_b  out  32 each  registered operands.
REQ-012 md_busy  in  1  unit busy.
REQ-013 md_hi, md_lo  in  32 each  unit result; remainder in md_hi and quotient in md_lo for divides.
REQ-014 hi, lo  out  32 each  architectural HI/LO registers.
REQ-015 md_err  out  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-017 IDLE, op_valid, op 0xx, not divide-by-zero: latch md_a=rs_val, md_b=rt_val, md_func=op[1:0]; go to ISSUE; stall=0.
REQ-018 ISSUE: md_start=1 for exactly this cycle; go to WAIT; clear the watchdog counter.
REQ-019 WAIT: stay while md_busy=1; on the first WAIT cycle with md_busy=0, load hi<=md_hi and lo<=md_lo, then go to IDLE.
REQ-020 md_func, md_a and md_b SHALL remain stable from ISSUE through the last WAIT cycle.
REQ-021 A unit that never raises md_busy (combinational multiply) SHALL complete in WAIT's first cycle; minimum issue-to-capture latency is 2 cycles.
REQ-022 Divide-by-zero (op 01x with rt_val=0) SHALL NOT issue; in that cycle, hi<=rs_val and lo<=32'hFFFFFFFF; stall=0.
REQ-023 IDLE MFHI/MFLO: rd_val=hi/lo in the same cycle; stall=0.
REQ-024 IDLE MTHI/MTLO: hi/lo<=rs_val at the next edge; the other register is unchanged.
REQ-025 stall SHALL equal op_valid & (state!=IDLE); this includes the WAIT capture cycle, so a reader always sees the new value after the stall.
REQ-026 When op_valid=0, rd_val SHALL be 0.
REQ-027 Watchdog: an 8-bit counter SHALL increment every WAIT cycle; if it reaches 255 while md_busy=1, the FSM SHALL go to IDLE, hi and lo SHALL be left unchanged, and md_err SHALL be set.
REQ-028 md_err SHALL clear only on reset.
REQ-029 md_start SHALL NEVER be asserted outside ISSUE.

Reset
REQ-030 reset in any state, including mid-WAIT, SHALL force: state=IDLE; hi, lo, md_a, md_b, md_func and the watchdog counter to 0; md_start=0; md_err=0.
REQ-031 Any result arriving after reset SHALL be ignored.
REQ-032 reset SHALL take precedence over every other event in the same cycle.

Structure
REQ-033 Opcode constants (op encodings, md_func encodings) and the WDOG_MAX=255 constant SHALL live in the shared package muldiv_pkg.
REQ-034 The FSM, watchdog and HI/LO registers SHALL be implemented inline with no sub-module; the mul/div unit SHALL be instantiated by the parent.

Verification
REQ-035 Multiply via a unit that never asserts busy: MULTU rs=0xFFFFFFFF, rt=2 -> md_start pulses once; 2 cycles later hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 DIV rs=-7, rt=2, with busy held for 32 cycles; MFLO presented the next cycle -> stall=1 for 33 cycles, then rd_val=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU rs=5, rt=0 -> no md_start; hi=5, lo=0xFFFFFFFF; stall=0.
REQ-038 MTHI 0x1234 then MFHI on the next cycle -> rd_val=0x1234, lo unchanged.
REQ-039 busy stuck at 1 -> after 255 WAIT cycles, md_err=1, state=IDLE, hi/lo unchanged.
REQ-040 reset pulse at WAIT cycle 3 -> all outputs 0; a later md_busy fall SHALL NOT modify hi/lo.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared opcode, mul/div function encodings and watchdog limit for the HI/LO
// controller and the mul/div unit it drives.
package muldiv_pkg;

   localparam logic [2:0] OP_MULTU = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_DIVU  = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_MFHI  = 3'b100;
   localparam logic [2:0] OP_MFLO  = 3'b101;
   localparam logic [2:0] OP_MTHI  = 3'b110;
   localparam logic [2:0] OP_MTLO  = 3'b111;

   localparam logic [1:0] FUNC_MULTU = 2'b00;
   localparam logic [1:0] FUNC_MULT  = 2'b01;
   localparam logic [1:0] FUNC_DIVU  = 2'b10;
   localparam logic [1:0] FUNC_DIV   = 2'b11;

   localparam logic [7:0] WDOG_MAX = 8'd255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Multiply/divide class ops have op[2]==0; divides additionally have op[1]==1.
   function automatic logic is_md_op(input logic [2:0] op);
      return ~op[2];
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return ~op[2] & op[1];
   endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register file and issue/wait controller for an external mul/div unit,
// with divide-by-zero bypass and a watchdog on the unit's busy handshake.
module hilo_ctrl
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        stall,
   output logic [31:0] rd_val,
   output logic        md_start,
   output logic [1:0]  md_func,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        md_busy,
   input  logic [31:0] md_hi,
   input  logic [31:0] md_lo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        md_err
);

   state_t     state_reg;
   state_t     state_next;
   logic [7:0] wdog_reg;
   logic [7:0] wdog_next;

   logic issue;
   logic div_zero;
   logic move_hi;
   logic move_lo;
   logic capture;
   logic timeout;

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      div_zero   = 1'b0;
      move_hi    = 1'b0;
      move_lo    = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;
      md_start   = 1'b0;
      wdog_next  = wdog_reg + 8'd1;
      stall      = op_valid && (state_reg != IDLE);
      rd_val     = 32'd0;

      case (state_reg)
         IDLE: begin
            if (op_valid) begin
               if (is_div_op(op) && (rt_val == 32'd0)) begin
                  div_zero = 1'b1;
               end else if (is_md_op(op)) begin
                  issue      = 1'b1;
                  state_next = ISSUE;
               end else if (op == OP_MTHI) begin
                  move_hi = 1'b1;
               end else if (op == OP_MTLO) begin
                  move_lo = 1'b1;
               end
            end
         end
         ISSUE: begin
            md_start   = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            // A completed result wins over a timeout landing in the same cycle.
            if (!md_busy) begin
               capture    = 1'b1;
               state_next = IDLE;
            end else if (wdog_next == WDOG_MAX) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (op_valid && (op == OP_MFHI)) begin
         rd_val = hi;
      end else if (op_valid && (op == OP_MFLO)) begin
         rd_val = lo;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         wdog_reg  <= 8'd0;
         md_func   <= 2'd0;
         md_a      <= 32'd0;
         md_b      <= 32'd0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         md_err    <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (issue) begin
            md_a    <= rs_val;
            md_b    <= rt_val;
            md_func <= op[1:0];
         end

         if (state_reg == ISSUE) begin
            wdog_reg <= 8'd0;
         end else if (state_reg == WAIT) begin
            wdog_reg <= wdog_next;
         end

         if (capture) begin
            hi <= md_hi;
            lo <= md_lo;
         end else if (div_zero) begin
            hi <= rs_val;
            lo <= 32'hFFFF_FFFF;
         end else if (move_hi) begin
            hi <= rs_val;
         end else if (move_lo) begin
            lo <= rs_val;
         end

         if (timeout) begin
            md_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl; a behavioural mul/div result model feeds
// md_hi/md_lo while each task drives md_busy by hand.
module tb_hilo_ctrl;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        stall;
   logic [31:0] rd_val;
   logic        md_start;
   logic [1:0]  md_func;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_busy;
   logic [31:0] md_hi;
   logic [31:0] md_lo;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        md_err;

   int n_cmp = 0;
   int n_bad = 0;

   hilo_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .op_valid (op_valid),
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .stall    (stall),
      .rd_val   (rd_val),
      .md_start (md_start),
      .md_func  (md_func),
      .md_a     (md_a),
      .md_b     (md_b),
      .md_busy  (md_busy),
      .md_hi    (md_hi),
      .md_lo    (md_lo),
      .hi       (hi),
      .lo       (lo),
      .md_err   (md_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural unit result (remainder in hi, quotient in lo for divides).
   logic signed [63:0] sa;
   logic signed [63:0] sb;
   logic        [63:0] prod;
   always_comb begin
      sa    = {{32{md_a[31]}}, md_a};
      sb    = {{32{md_b[31]}}, md_b};
      prod  = 64'd0;
      md_hi = 32'd0;
      md_lo = 32'd0;
      case (md_func)
         2'b00: begin
            prod  = {32'd0, md_a} * {32'd0, md_b};
            md_hi = prod[63:32];
            md_lo = prod[31:0];
         end
         2'b01: begin
            prod  = sa * sb;
            md_hi = prod[63:32];
            md_lo = prod[31:0];
         end
         2'b10: if (md_b != 32'd0) begin
            md_hi = md_a % md_b;
            md_lo = md_a / md_b;
         end
         default: if (md_b != 32'd0) begin
            md_hi = $signed(md_a) % $signed(md_b);
            md_lo = $signed(md_a) / $signed(md_b);
         end
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; op_valid = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; md_busy = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      op_valid = 1'b1; op = 3'b100;
      #1;
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
      n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
      n_cmp++; if (md_a !== 32'd0 || md_b !== 32'd0 || md_func !== 2'd0) begin n_bad++; $display("FAIL reset_operands got=%h/%h/%b exp=0/0/00", md_a, md_b, md_func); end
      n_cmp++; if (md_err !== 1'b0 || md_start !== 1'b0) begin n_bad++; $display("FAIL reset_flags got err=%b start=%b exp=0/0", md_err, md_start); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
      op_valid = 1'b0;
      $display("reset: hi=%h lo=%h err=%b", hi, lo, md_err);
   endtask

   task automatic test_multu();
      int starts;
      md_busy = 1'b0;
      op_valid = 1'b1; op = 3'b000; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
      #1;
      n_cmp++; if (stall !== 1'b0 || md_start !== 1'b0) begin n_bad++; $display("FAIL multu_accept got stall=%b start=%b exp=0/0", stall, md_start); end
      tick();
      op_valid = 1'b0;
      #1;
      starts = 0;
      n_cmp++; if (md_a !== 32'hFFFF_FFFF || md_b !== 32'd2 || md_func !== 2'b00) begin n_bad++; $display("FAIL multu_latch got=%h/%h/%b exp=ffffffff/00000002/00", md_a, md_b, md_func); end
      if (md_start) starts++;
      tick();
      if (md_start) starts++;
      tick();
      if (md_start) starts++;
      n_cmp++; if (starts !== 1) begin n_bad++; $display("FAIL multu_start_pulses got=%0d exp=1", starts); end
      n_cmp++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_result got=%h_%h exp=00000001_fffffffe", hi, lo); end
      $display("multu: ffffffff*2 -> hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_div_busy();
      int n_stall;
      int starts;
      op_valid = 1'b1; op = 3'b011; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2; md_busy = 1'b0;
      tick();
      op = 3'b101; rs_val = 32'd0; rt_val = 32'd0;
      n_stall = 0;
      starts = 0;
      for (int i = 0; i < 100; i++) begin
         md_busy = (i < 32);
         #1;
         if (!stall) break;
         if (md_start) starts++;
         if (i == 32) begin
            n_cmp++; if (md_a !== 32'hFFFF_FFF9 || md_b !== 32'd2 || md_func !== 2'b11) begin n_bad++; $display("FAIL div_operands_held got=%h/%h/%b exp=fffffff9/00000002/11", md_a, md_b, md_func); end
         end
         n_stall++;
         tick();
      end
      md_busy = 1'b0;
      n_cmp++; if (n_stall !== 33) begin n_bad++; $display("FAIL div_stall_cycles got=%0d exp=33", n_stall); end
      n_cmp++; if (starts !== 1) begin n_bad++; $display("FAIL div_start_pulses got=%0d exp=1", starts); end
      n_cmp++; if (rd_val !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_mflo got=%h exp=fffffffd", rd_val); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_rem got=%h exp=ffffffff", hi); end
      op_valid = 1'b0;
      #1;
      n_cmp++; if (rd_val !== 32'd0) begin n_bad++; $display("FAIL rd_idle_zero got=%h exp=00000000", rd_val); end
      $display("div: -7/2 stall=%0d lo=%h hi=%h", n_stall, lo, hi);
   endtask

   task automatic test_div_zero();
      op_valid = 1'b1; op = 3'b010; rs_val = 32'd5; rt_val = 32'd0;
      #1;
      n_cmp++; if (stall !== 1'b0 || md_start !== 1'b0) begin n_bad++; $display("FAIL dbz_accept got stall=%b start=%b exp=0/0", stall, md_start); end
      tick();
      op_valid = 1'b0;
      #1;
      n_cmp++; if (md_start !== 1'b0) begin n_bad++; $display("FAIL dbz_no_issue got start=%b exp=0", md_start); end
      n_cmp++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dbz_result got=%h_%h exp=00000005_ffffffff", hi, lo); end
      n_cmp++; if (md_a !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL dbz_operand_kept got=%h exp=fffffff9", md_a); end
      $display("divu: 5/0 -> hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_move();
      op_valid = 1'b1; op = 3'b110; rs_val = 32'h0000_1234;
      tick();
      op = 3'b100; rs_val = 32'd0;
      #1;
      n_cmp++; if (rd_val !== 32'h0000_1234 || stall !== 1'b0) begin n_bad++; $display("FAIL mthi_mfhi got rd=%h stall=%b exp=00001234/0", rd_val, stall); end
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mthi_lo_kept got=%h exp=ffffffff", lo); end
      op = 3'b111; rs_val = 32'h0000_ABCD;
      tick();
      op = 3'b101; rs_val = 32'd0;
      #1;
      n_cmp++; if (rd_val !== 32'h0000_ABCD) begin n_bad++; $display("FAIL mtlo_mflo got=%h exp=0000abcd", rd_val); end
      n_cmp++; if (hi !== 32'h0000_1234) begin n_bad++; $display("FAIL mtlo_hi_kept got=%h exp=00001234", hi); end
      op_valid = 1'b0;
      $display("move: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_watchdog();
      int n_wait;
      md_busy = 1'b1;
      op_valid = 1'b1; op = 3'b001; rs_val = 32'd3; rt_val = 32'd4;
      tick();
      op_valid = 1'b0;
      tick();
      n_wait = 0;
      for (int i = 0; i < 400; i++) begin
         if (md_err) break;
         n_wait++;
         tick();
      end
      n_cmp++; if (n_wait !== 255) begin n_bad++; $display("FAIL wdog_cycles got=%0d exp=255", n_wait); end
      n_cmp++; if (hi !== 32'h0000_1234 || lo !== 32'h0000_ABCD) begin n_bad++; $display("FAIL wdog_hilo_kept got=%h_%h exp=00001234_0000abcd", hi, lo); end
      op_valid = 1'b1; op = 3'b100;
      #1;
      n_cmp++; if (stall !== 1'b0 || rd_val !== 32'h0000_1234) begin n_bad++; $display("FAIL wdog_idle got stall=%b rd=%h exp=0/00001234", stall, rd_val); end
      md_busy = 1'b0;
      op = 3'b001; rs_val = 32'hFFFF_FFFD; rt_val = 32'd4;
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF4) begin n_bad++; $display("FAIL mult_after_wdog got=%h_%h exp=ffffffff_fffffff4", hi, lo); end
      n_cmp++; if (md_err !== 1'b1) begin n_bad++; $display("FAIL md_err_sticky got=%b exp=1", md_err); end
      $display("watchdog: waits=%0d err=%b then mult hi=%h lo=%h", n_wait, md_err, hi, lo);
   endtask

   task automatic test_reset_mid_wait();
      md_busy = 1'b1;
      op_valid = 1'b1; op = 3'b010; rs_val = 32'd100; rt_val = 32'd7;
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_cmp++; if (hi !== 32'd0 || lo !== 32'd0 || md_err !== 1'b0) begin n_bad++; $display("FAIL midreset_regs got=%h_%h err=%b exp=0_0 err=0", hi, lo, md_err); end
      n_cmp++; if (md_a !== 32'd0 || md_b !== 32'd0 || md_func !== 2'd0 || md_start !== 1'b0) begin n_bad++; $display("FAIL midreset_unit got=%h/%h/%b start=%b exp=0/0/00 start=0", md_a, md_b, md_func, md_start); end
      md_busy = 1'b0;
      tick();
      tick();
      tick();
      op_valid = 1'b1; op = 3'b101;
      #1;
      n_cmp++; if (hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin n_bad++; $display("FAIL midreset_late_result got=%h_%h stall=%b exp=0_0 stall=0", hi, lo, stall); end
      op_valid = 1'b0;
      $display("mid-wait reset: hi=%h lo=%h", hi, lo);
   endtask

   initial begin
      test_reset();
      test_multu();
      test_div_busy();
      test_div_zero();
      test_move();
      test_watchdog();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
